// File: rtl/t02_div_pkg.sv
// t02 divider shared types and constants.
// Also used by the control unit to map funct3 onto div_op_t.
package t02_div_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      DIV_S = 2'd0,
      DIV_U = 2'd1,
      REM_S = 2'd2,
      REM_U = 2'd3
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
   localparam logic [XLEN-1:0] SIGNED_MIN =
      {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/t02_divider_if.sv
// Start/done handshake and operand/result bundle
// between the execute stage and the divider.
interface t02_divider_if #(
   parameter int WIDTH = 32
);
   import t02_div_pkg::*;

   logic             start;
   div_op_t          op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor,
      output busy, done, result
   );

endinterface

// File: rtl/t02_div_step.sv
// One restoring division iteration:
// shift in a dividend bit, trial-subtract, keep or restore.
module t02_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, dvs};
   assign q_bit   = ~diff[WIDTH];
   assign rem_out = q_bit ? diff[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

endmodule

// File: rtl/t02_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit,
// one restoring quotient bit per clock.
module t02_divider
   import t02_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic           clk,
   input logic           rst,
   t02_divider_if.slave  bus
);

   div_state_t       state;
   div_state_t       state_nx;
   div_op_t          op_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dq_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] res_q;
   logic             neg_q;
   logic             neg_r;
   logic             done_q;

   logic             is_signed;
   logic             div_zero;
   logic             ovf;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH-1:0] rem_nx;
   logic             q_bit;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign is_signed = ~bus.op[0];
   assign div_zero  = (bus.divisor == '0);
   assign ovf = is_signed
      && (bus.dividend == SIGNED_MIN)
      && (bus.divisor == DIV_BY_ZERO_Q);

   assign a_abs = (is_signed && bus.dividend[WIDTH-1])
      ? -bus.dividend : bus.dividend;
   assign b_abs = (is_signed && bus.divisor[WIDTH-1])
      ? -bus.divisor : bus.divisor;

   assign q_fix = neg_q ? -dq_q : dq_q;
   assign r_fix = neg_r ? -rem_q : rem_q;

   // dq_q shifts dividend bits out the top and quotient bits in
   t02_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .bit_in  (dq_q[WIDTH-1]),
      .dvs     (dvs_q),
      .rem_out (rem_nx),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (bus.start)
               state_nx = (div_zero || ovf) ? FIN : CALC;
         CALC:
            if (cnt == CNT_W'(1)) state_nx = FIN;
         FIN:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = (state != IDLE);
      bus.done   = done_q;
      bus.result = res_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= DIV_S;
         cnt    <= '0;
         rem_q  <= '0;
         dq_q   <= '0;
         dvs_q  <= '0;
         res_q  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: if (bus.start) begin
               op_q <= bus.op;
               if (div_zero) begin
                  dq_q  <= DIV_BY_ZERO_Q;
                  rem_q <= bus.dividend;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end else if (ovf) begin
                  dq_q  <= SIGNED_MIN;
                  rem_q <= '0;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end else begin
                  dq_q  <= a_abs;
                  dvs_q <= b_abs;
                  rem_q <= '0;
                  neg_q <= is_signed
                     & (bus.dividend[WIDTH-1]
                     ^ bus.divisor[WIDTH-1]);
                  neg_r <= is_signed
                     & bus.dividend[WIDTH-1];
                  cnt   <= CNT_W'(WIDTH);
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               dq_q  <= {dq_q[WIDTH-2:0], q_bit};
               cnt   <= cnt - 1'b1;
            end
            FIN: begin
               res_q  <= op_q[1] ? r_fix : q_fix;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/t02_divider.md
Name: t02_divider

Overview:
- Iterative RV32M divide/remainder unit covering DIV, DIVU, REM and REMU, with a start/done handshake.
- Sits beside the single-cycle integer ALU in the execute stage and takes the same operand buses.
- The control unit stalls the pipeline while busy is high and captures result on the done pulse.
- Restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 0 = DIV, 1 = DIVU, 2 = REM, 3 = REMU.
- dividend  input  WIDTH  rs1 operand (inputA).
- divisor  input  WIDTH  rs2 operand (inputB).
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  quotient or remainder; held until the next completion.

Behaviour:
- Reset (asynchronous, active-high)
  - State goes to IDLE.
  - busy, done, result, counter and all internal registers go to 0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIN.
- IDLE
  - On an edge with start=1, latch op, dividend and divisor.
  - Special cases, checked at this edge:
    - Divisor zero: go to FIN with quotient = all ones (0xFFFFFFFF) and remainder = dividend. Applies to both signed and unsigned ops.
    - Signed op with dividend = 0x80000000 and divisor = 0xFFFFFFFF: go to FIN with quotient = 0x80000000 and remainder = 0.
  - Otherwise:
    - For signed ops, take the absolute values of both operands.
    - Record neg_q = sign(dividend) XOR sign(divisor).
    - Record neg_r = sign(dividend).
    - For unsigned ops, neg_q and neg_r are 0.
    - Clear the partial remainder, load the counter with WIDTH, go to CALC.
  - busy goes high at this edge.
- CALC
  - Each edge:
    - Shift {partial remainder, dividend register} left by 1.
    - Trial-subtract the magnitude divisor from the partial remainder in WIDTH+1 bits.
    - If the difference is non-negative, keep it and set quotient bit = 1; otherwise restore and set the bit to 0.
    - Decrement the counter.
  - After the edge that brings the counter to 0, go to FIN. CALC lasts exactly WIDTH edges.
- FIN, single edge:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Drive result with the quotient (DIV/DIVU) or remainder (REM/REMU).
  - done = 1 and busy = 0 for the following cycle, then return to IDLE.
- Latency, counting the start edge as E0:
  - Normal operation: done is high in the cycle after E(WIDTH+1), i.e. E33 for the default width.
  - Special cases: done is high in the cycle after E1.
- done is high for exactly one cycle. If start is high in that cycle, it is accepted at the next edge because the state is IDLE. Back-to-back operations lose no cycle.
- start while busy is ignored; operand changes during CALC have no effect.
- result changes only at the FIN edge and at reset.
- All arithmetic is two's complement modulo 2^WIDTH. Sign bits are bit WIDTH-1.

Decomposition:
- Package t02_div_pkg holds:
  - enum div_op_t {DIV_S=0, DIV_U=1, REM_S=2, REM_U=3};
  - enum div_state_t {IDLE, CALC, FIN};
  - constants DIV_BY_ZERO_Q = all ones and SIGNED_MIN = 0x80000000.
- The same package is imported by the control unit to decode funct3 onto op.
- One natural sub-module, t02_div_step: a combinational single restoring iteration.
  - Takes the partial remainder, next dividend bit and divisor.
  - Returns the new partial remainder and the quotient bit.
- The FSM, counter and sign fix-up stay in t02_divider.

Test Plan:
- DIVU 100 / 7, start one cycle -> busy 1; done pulse in the cycle after E33; result = 14. REMU same operands -> 2.
- DIV -100 (0xFFFFFF9C) / 7 -> result 0xFFFFFFF2 (-14). REM same operands -> 0xFFFFFFFE (-2). DIV 100 / -7 -> -14; REM -> 2.
- Divide by zero: DIV 0x12345678 / 0 -> done after E1 with 0xFFFFFFFF; REMU same operands -> 0x12345678.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after E1; REM same operands -> 0.
- Handshake:
  - Pulse start again at E5 while busy, with different operands -> ignored; original result delivered.
  - Start held high in the done cycle -> second operation accepted and done again 34 edges later.
- Reset: assert rst asynchronously mid-CALC (E10) -> busy/done/result = 0 immediately, no done pulse. After release, DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
